mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clk  in  1  system clock; all state updates on posedge Clk.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Mem_OE  in  1  read request from the instruction sequencer; held high for the whole read.
REQ-004 Mem_WE  in  1  write request from the instruction sequencer; held high for the whole write.
REQ-005 MAR  in  16  word address.
REQ-006 MDR  in  16  write data.
REQ-007 Switches  in  16  board switch value.
REQ-008 Data_from_SRAM  in  16  SRAM read bus.
REQ-009 Data_to_SRAM  out  16  SRAM write bus; valid while SRAM_DATA_EN=1.
REQ-010 SRAM_DATA_EN  out  1  tristate enable for the SRAM data pins.
REQ-011 Data_to_CPU  out  16  registered read data, routed to the MDR input.
REQ-012 SRAM_ADDR  out  20  {4'b0, latched MAR}.
REQ-013 CE_N, UB_N, LB_N, OE_N, WE_N  out  1 each  active-low SRAM strobes.
REQ-014 Busy  out  1  high in any state other than IDLE.
REQ-015 HEX_DATA  out  16  hex display register; present only with MEM_IO_MAP_EN.

Function
REQ-016 The FSM SHALL have states IDLE, RD_1, RD_2, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-017 In IDLE with Mem_WE=1, the next state SHALL be WR_SETUP; otherwise, with Mem_OE=1, RD_1; otherwise IDLE. Write wins when both are high.
REQ-018 On leaving IDLE, MAR (and MDR for a write) SHALL be latched; SRAM_ADDR and Data_to_SRAM come only from the latched copies.
REQ-019 Read path: RD_1 -> RD_2 -> RD_CAP -> DONE. CE_N=0, UB_N=0, LB_N=0 and OE_N=0 in RD_1 and RD_2. Data_to_CPU SHALL be loaded on the edge leaving RD_2.
REQ-020 Read latency: if Mem_OE is first sampled high at edge k, Data_to_CPU SHALL be valid from edge k+3 and SHALL hold until the next read capture.
REQ-021 Write path: WR_SETUP -> WR_PULSE -> WR_HOLD -> DONE. CE_N=0, UB_N=0, LB_N=0 and SRAM_DATA_EN=1 in all three states; WE_N=0 only in WR_PULSE. OE_N SHALL be 1 throughout.
REQ-022 WE_N=0 and OE_N=0 SHALL never be asserted in the same cycle.
REQ-023 DONE SHALL stay in DONE while Mem_OE|Mem_WE=1 and return to IDLE when both are 0. A request held high never triggers a second access.
REQ-024 If Mem_OE drops during RD_1 or RD_2, the next state SHALL be IDLE and Data_to_CPU SHALL be unchanged.
REQ-025 If Mem_WE drops during the write path, the sequence SHALL still complete through WR_HOLD. No truncated WE pulse is allowed.
REQ-026 Strobes SHALL be driven from registered state only, so they are glitch-free.

Reset
REQ-027 When Reset=1 at a posedge, the next state SHALL be IDLE. Data_to_CPU=16'h0000, HEX_DATA=16'h0000, latched address and data=0.
REQ-028 While in IDLE: all strobes=1, SRAM_DATA_EN=0, Busy=0.
REQ-029 Reset SHALL take priority over any request, including in the middle of a write.

Configuration
REQ-030 With MEM_IO_MAP_EN defined: a read with latched MAR=16'hFFFF SHALL capture Switches into Data_to_CPU with SRAM strobes held inactive. A write to 16'hFFFF SHALL load HEX_DATA in WR_PULSE with SRAM strobes held inactive. Timing SHALL be identical to an SRAM access.
REQ-031 Without MEM_IO_MAP_EN: HEX_DATA SHALL be absent and address 16'hFFFF SHALL be an ordinary SRAM location.

Verification
REQ-032 Reset, then Mem_OE high 4 cycles with MAR=16'h0010 and SRAM returning 16'hBEEF -> OE_N low 2 cycles, Data_to_CPU=16'hBEEF at edge k+3, then IDLE.
REQ-033 Mem_WE high 4 cycles with MAR=16'h0020 and MDR=16'h1234 -> single 1-cycle WE_N pulse, SRAM_ADDR=20'h00020, Data_to_SRAM=16'h1234 while SRAM_DATA_EN=1.
REQ-034 Mem_OE and Mem_WE high together -> write sequence only; OE_N stays 1.
REQ-035 Mem_OE dropped after 1 cycle -> IDLE next edge, Data_to_CPU keeps its old value; Reset asserted in WR_PULSE -> IDLE with WE_N=1 next cycle.
REQ-036 With MEM_IO_MAP_EN: read of MAR=16'hFFFF with Switches=16'h00A5 -> Data_to_CPU=16'h00A5 and CE_N stays 1; write of 16'h4321 -> HEX_DATA=16'h4321.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequences single SRAM reads/writes for the instruction sequencer with registered strobes.
// Optional MEM_IO_MAP_EN maps address 16'hFFFF to the board switches (read) and HEX_DATA (write).
module mem_access_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic [15:0] Switches,
   input  logic [15:0] Data_from_SRAM,
   output logic [15:0] Data_to_SRAM,
   output logic        SRAM_DATA_EN,
   output logic [15:0] Data_to_CPU,
   output logic [19:0] SRAM_ADDR,
   output logic        CE_N,
   output logic        UB_N,
   output logic        LB_N,
   output logic        OE_N,
   output logic        WE_N,
`ifdef MEM_IO_MAP_EN
   output logic [15:0] HEX_DATA,
`endif
   output logic        Busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_1     = 3'd1;
   localparam logic [2:0] RD_2     = 3'd2;
   localparam logic [2:0] RD_CAP   = 3'd3;
   localparam logic [2:0] WR_SETUP = 3'd4;
   localparam logic [2:0] WR_PULSE = 3'd5;
   localparam logic [2:0] WR_HOLD  = 3'd6;
   localparam logic [2:0] DONE     = 3'd7;

   localparam logic [15:0] IO_ADDR = 16'hFFFF;

   logic [2:0]  state, nxt_state;
   logic [15:0] mar_q, mdr_q, nxt_mar, nxt_mdr;
   logic        io_hit, rd_act, wr_act, pulse_act, start;

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:     if (Mem_WE)      nxt_state = WR_SETUP;
                   else if (Mem_OE) nxt_state = RD_1;
         RD_1:     nxt_state = Mem_OE ? RD_2   : IDLE;
         RD_2:     nxt_state = Mem_OE ? RD_CAP : IDLE;
         RD_CAP:   nxt_state = DONE;
         WR_SETUP: nxt_state = WR_PULSE;
         WR_PULSE: nxt_state = WR_HOLD;
         WR_HOLD:  nxt_state = DONE;
         DONE:     nxt_state = (Mem_OE | Mem_WE) ? DONE : IDLE;
         default:  nxt_state = IDLE;
      endcase
   end

   // Address/data are captured only when leaving IDLE so the bus stays stable mid-access.
   always_comb begin
      start   = (state == IDLE) && (Mem_OE || Mem_WE);
      nxt_mar = start ? MAR : mar_q;
      nxt_mdr = (start && Mem_WE) ? MDR : mdr_q;
   end

`ifdef MEM_IO_MAP_EN
   assign io_hit = (nxt_mar == IO_ADDR);
`else
   assign io_hit = 1'b0;
`endif

   // Strobes are decoded from the next state and registered, so pins never see decode glitches.
   always_comb begin
      rd_act    = ((nxt_state == RD_1) || (nxt_state == RD_2)) && !io_hit;
      wr_act    = ((nxt_state == WR_SETUP) || (nxt_state == WR_PULSE) ||
                   (nxt_state == WR_HOLD)) && !io_hit;
      pulse_act = (nxt_state == WR_PULSE) && !io_hit;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         mar_q        <= '0;
         mdr_q        <= '0;
         Data_to_CPU  <= '0;
         CE_N         <= 1'b1;
         UB_N         <= 1'b1;
         LB_N         <= 1'b1;
         OE_N         <= 1'b1;
         WE_N         <= 1'b1;
         SRAM_DATA_EN <= 1'b0;
         Busy         <= 1'b0;
      end else begin
         state        <= nxt_state;
         mar_q        <= nxt_mar;
         mdr_q        <= nxt_mdr;
         CE_N         <= !(rd_act || wr_act);
         UB_N         <= !(rd_act || wr_act);
         LB_N         <= !(rd_act || wr_act);
         OE_N         <= !rd_act;
         WE_N         <= !pulse_act;
         SRAM_DATA_EN <= wr_act;
         Busy         <= (nxt_state != IDLE);
         if (state == RD_2 && Mem_OE) begin
`ifdef MEM_IO_MAP_EN
            Data_to_CPU <= (mar_q == IO_ADDR) ? Switches : Data_from_SRAM;
`else
            Data_to_CPU <= Data_from_SRAM;
`endif
         end
      end
   end

`ifdef MEM_IO_MAP_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         HEX_DATA <= '0;
      else if (state == WR_PULSE && mar_q == IO_ADDR)
         HEX_DATA <= mdr_q;
   end
`else
   logic unused_sw;
   assign unused_sw = ^Switches;
`endif

   assign SRAM_ADDR    = {4'b0000, mar_q};
   assign Data_to_SRAM = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; io-map checks compile in with MEM_IO_MAP_EN.
module tb_mem_access_ctrl;

   logic        Clk, Reset, Mem_OE, Mem_WE;
   logic [15:0] MAR, MDR, Switches, Data_from_SRAM;
   logic [15:0] Data_to_SRAM, Data_to_CPU;
   logic        SRAM_DATA_EN, CE_N, UB_N, LB_N, OE_N, WE_N, Busy;
   logic [19:0] SRAM_ADDR;
`ifdef MEM_IO_MAP_EN
   logic [15:0] HEX_DATA;
`endif

   int ntests = 0;
   int nfail  = 0;
   int we_lows;

   mem_access_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .MAR(MAR), .MDR(MDR), .Switches(Switches), .Data_from_SRAM(Data_from_SRAM),
      .Data_to_SRAM(Data_to_SRAM), .SRAM_DATA_EN(SRAM_DATA_EN),
      .Data_to_CPU(Data_to_CPU), .SRAM_ADDR(SRAM_ADDR),
      .CE_N(CE_N), .UB_N(UB_N), .LB_N(LB_N), .OE_N(OE_N), .WE_N(WE_N),
`ifdef MEM_IO_MAP_EN
      .HEX_DATA(HEX_DATA),
`endif
      .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
      MAR = 16'h0; MDR = 16'h0; Switches = 16'h0; Data_from_SRAM = 16'h0;
      tick(); tick();
      chk("rst_ce",   {31'd0, CE_N}, 1);
      chk("rst_oe",   {31'd0, OE_N}, 1);
      chk("rst_we",   {31'd0, WE_N}, 1);
      chk("rst_en",   {31'd0, SRAM_DATA_EN}, 0);
      chk("rst_busy", {31'd0, Busy}, 0);
      chk("rst_data", {16'd0, Data_to_CPU}, 0);
      chk("rst_addr", {12'd0, SRAM_ADDR}, 0);
      Reset = 1'b0;
      tick();

      // Read 0x0010 returning BEEF, Mem_OE held for 4 sampled edges
      Mem_OE = 1'b1; MAR = 16'h0010; Data_from_SRAM = 16'hBEEF;
      tick();                                  // edge k -> RD_1
      MAR = 16'h0099;                          // must not affect latched address
      chk("rd1_oe",   {31'd0, OE_N}, 0);
      chk("rd1_ce",   {31'd0, CE_N}, 0);
      chk("rd1_ub",   {31'd0, UB_N}, 0);
      chk("rd1_busy", {31'd0, Busy}, 1);
      chk("rd1_addr", {12'd0, SRAM_ADDR}, 32'h00010);
      tick();                                  // k+1 -> RD_2
      chk("rd2_oe",   {31'd0, OE_N}, 0);
      chk("rd2_addr", {12'd0, SRAM_ADDR}, 32'h00010);
      tick();                                  // k+2 -> RD_CAP
      chk("rdcap_oe", {31'd0, OE_N}, 1);
      chk("rdcap_ce", {31'd0, CE_N}, 1);
      tick();                                  // k+3 -> DONE
      chk("rd_data",  {16'd0, Data_to_CPU}, 32'hBEEF);
      chk("done_busy",{31'd0, Busy}, 1);
      Mem_OE = 1'b0;
      Data_from_SRAM = 16'h0000;
      tick();                                  // DONE -> IDLE
      chk("rd_idle",  {31'd0, Busy}, 0);
      chk("rd_hold",  {16'd0, Data_to_CPU}, 32'hBEEF);

      // Write 0x1234 to 0x0020, Mem_WE held for 4 sampled edges
      Mem_WE = 1'b1; MAR = 16'h0020; MDR = 16'h1234;
      tick();                                  // WR_SETUP
      MAR = 16'h0000; MDR = 16'h0000;
      chk("ws_en",   {31'd0, SRAM_DATA_EN}, 1);
      chk("ws_we",   {31'd0, WE_N}, 1);
      chk("ws_oe",   {31'd0, OE_N}, 1);
      chk("ws_ce",   {31'd0, CE_N}, 0);
      chk("ws_addr", {12'd0, SRAM_ADDR}, 32'h00020);
      chk("ws_data", {16'd0, Data_to_SRAM}, 32'h1234);
      tick();                                  // WR_PULSE
      chk("wp_we",   {31'd0, WE_N}, 0);
      chk("wp_oe",   {31'd0, OE_N}, 1);
      chk("wp_data", {16'd0, Data_to_SRAM}, 32'h1234);
      tick();                                  // WR_HOLD
      chk("wh_we",   {31'd0, WE_N}, 1);
      chk("wh_en",   {31'd0, SRAM_DATA_EN}, 1);
      tick();                                  // DONE
      chk("wd_en",   {31'd0, SRAM_DATA_EN}, 0);
      chk("wd_ce",   {31'd0, CE_N}, 1);
      chk("wd_busy", {31'd0, Busy}, 1);
      Mem_WE = 1'b0;
      tick();
      chk("wr_idle", {31'd0, Busy}, 0);

      // Both requests high: write only, OE_N never low, one WE pulse
      Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = 16'h0030; MDR = 16'h5555;
      we_lows = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("both_oe", {31'd0, OE_N}, 1);
         if (WE_N == 1'b0) we_lows++;
      end
      chk("both_pulses", we_lows, 1);
      chk("both_data", {16'd0, Data_to_CPU}, 32'hBEEF);
      Mem_OE = 1'b0; Mem_WE = 1'b0;
      tick();
      chk("both_idle", {31'd0, Busy}, 0);

      // Mem_WE dropped after one cycle: full write still completes
      Mem_WE = 1'b1; MAR = 16'h0050; MDR = 16'hA0A0;
      tick();                                  // WR_SETUP
      Mem_WE = 1'b0;
      tick();                                  // WR_PULSE
      chk("short_we_pulse", {31'd0, WE_N}, 0);
      tick();                                  // WR_HOLD
      chk("short_we_hold",  {31'd0, SRAM_DATA_EN}, 1);
      tick();                                  // DONE
      tick();                                  // IDLE
      chk("short_we_idle",  {31'd0, Busy}, 0);

      // Mem_OE dropped during RD_1: abort, data unchanged
      Mem_OE = 1'b1; MAR = 16'h0040; Data_from_SRAM = 16'h1111;
      tick();                                  // RD_1
      chk("abort_rd1", {31'd0, OE_N}, 0);
      Mem_OE = 1'b0;
      tick();
      chk("abort_busy", {31'd0, Busy}, 0);
      chk("abort_oe",   {31'd0, OE_N}, 1);
      tick(); tick();
      chk("abort_data", {16'd0, Data_to_CPU}, 32'hBEEF);

      // Reset in WR_PULSE
      Mem_WE = 1'b1; MAR = 16'h0060; MDR = 16'h7777;
      tick();                                  // WR_SETUP
      tick();                                  // WR_PULSE
      chk("rstw_pulse", {31'd0, WE_N}, 0);
      Reset = 1'b1;
      tick();
      chk("rstw_we",   {31'd0, WE_N}, 1);
      chk("rstw_en",   {31'd0, SRAM_DATA_EN}, 0);
      chk("rstw_busy", {31'd0, Busy}, 0);
      chk("rstw_data", {16'd0, Data_to_CPU}, 0);
      chk("rstw_addr", {12'd0, SRAM_ADDR}, 0);
      Reset = 1'b0; Mem_WE = 1'b0;
      tick();

`ifdef MEM_IO_MAP_EN
      Mem_OE = 1'b1; MAR = 16'hFFFF; Switches = 16'h00A5; Data_from_SRAM = 16'hDEAD;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("io_rd_ce", {31'd0, CE_N}, 1);
         chk("io_rd_oe", {31'd0, OE_N}, 1);
      end
      chk("io_rd_data", {16'd0, Data_to_CPU}, 32'h00A5);
      Mem_OE = 1'b0;
      tick();
      Mem_WE = 1'b1; MDR = 16'h4321;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("io_wr_we", {31'd0, WE_N}, 1);
         chk("io_wr_ce", {31'd0, CE_N}, 1);
         chk("io_wr_en", {31'd0, SRAM_DATA_EN}, 0);
      end
      chk("io_hex", {16'd0, HEX_DATA}, 32'h4321);
      Mem_WE = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
